// File: rtl/egg_timer_sequencer_pkg.sv
// Shared types and constants for the egg timer sequencer and its prescaler.
package egg_timer_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StAlarm
    } state_e;

    localparam int unsigned TIME_W = 12;

    function automatic int unsigned presc_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Seconds prescaler: counts 0 .. TICK_DIV-1 while enabled, flags the wrap cycle.
module tick_prescaler
    import egg_timer_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = presc_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wrap is only reported when counting, so a held count never ticks.
    assign tick = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/egg_timer_sequencer.sv
// Egg timer control: load/run/pause/resume/clear sequencing, countdown register
// and alarm phase. All outputs are registered.
module egg_timer_sequencer
    import egg_timer_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] preset_in,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    output logic [TIME_W-1:0] remaining,
    output logic              sec_tick,
    output logic              running,
    output logic              paused,
    output logic              alarm,
    output logic              done
);

    localparam int unsigned ACNT_W = $clog2(ALARM_SECS + 1);
    localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_SECS - 1);

    state_e            state_q;
    logic [ACNT_W-1:0] alarm_cnt_q;
    logic              any_cmd;
    logic              presc_en;
    logic              presc_clr;
    logic              tick;

    assign any_cmd = start | pause | clear;

    // A pause or clear in RUN must hold the prescaler so a wrap due that cycle is lost.
    always_comb begin
        presc_en  = 1'b0;
        presc_clr = 1'b0;
        unique case (state_q)
            StIdle:   presc_clr = 1'b1;
            StRun: begin
                presc_en  = !pause && !clear;
                presc_clr = clear;
            end
            StPaused: presc_clr = clear;
            StAlarm: begin
                presc_en  = !any_cmd;
                presc_clr = any_cmd;
            end
            default: ;
        endcase
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining   <= '0;
            alarm_cnt_q <= '0;
            sec_tick    <= 1'b0;
            running     <= 1'b0;
            paused      <= 1'b0;
            alarm       <= 1'b0;
            done        <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            done     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !pause && !clear && (preset_in != '0)) begin
                        state_q   <= StRun;
                        remaining <= preset_in;
                        running   <= 1'b1;
                    end
                end
                StRun: begin
                    if (clear) begin
                        state_q   <= StIdle;
                        remaining <= '0;
                        running   <= 1'b0;
                    end else if (pause) begin
                        state_q <= StPaused;
                        running <= 1'b0;
                        paused  <= 1'b1;
                    end else if (tick) begin
                        sec_tick <= 1'b1;
                        if (remaining != '0) begin
                            remaining <= remaining - TIME_W'(1);
                        end
                        if (remaining <= TIME_W'(1)) begin
                            state_q     <= StAlarm;
                            running     <= 1'b0;
                            alarm       <= 1'b1;
                            done        <= 1'b1;
                            alarm_cnt_q <= '0;
                        end
                    end
                end
                StPaused: begin
                    if (clear) begin
                        state_q   <= StIdle;
                        remaining <= '0;
                        paused    <= 1'b0;
                    end else if (start && !pause) begin
                        state_q <= StRun;
                        paused  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                StAlarm: begin
                    // Any command acknowledges; a start here never reloads the countdown.
                    if (any_cmd) begin
                        state_q     <= StIdle;
                        alarm       <= 1'b0;
                        alarm_cnt_q <= '0;
                    end else if (tick) begin
                        sec_tick <= 1'b1;
                        if (alarm_cnt_q == ALARM_LAST) begin
                            state_q     <= StIdle;
                            alarm       <= 1'b0;
                            alarm_cnt_q <= '0;
                        end else begin
                            alarm_cnt_q <= alarm_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_egg_timer_sequencer.sv
// Self-checking bench for egg_timer_sequencer with TICK_DIV=4, ALARM_SECS=2.
module tb_egg_timer_sequencer;
    import egg_timer_sequencer_pkg::*;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned ALARM_SECS = 2;

    typedef struct {
        int                cyc;
        logic [TIME_W-1:0] rem;
    } tick_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [TIME_W-1:0] preset_in = '0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              clear = 1'b0;
    logic [TIME_W-1:0] remaining;
    logic              sec_tick;
    logic              running;
    logic              paused;
    logic              alarm;
    logic              done;

    tick_t exp_q[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    egg_timer_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .preset_in (preset_in),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .remaining (remaining),
        .sec_tick  (sec_tick),
        .running   (running),
        .paused    (paused),
        .alarm     (alarm),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input int c, input logic [TIME_W-1:0] r);
        tick_t t;
        t.cyc = c;
        t.rem = r;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        step(2);
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL reset_hold: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
        rst = 1'b0;
        step(3);
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL reset_release: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
    endtask

    task automatic test_countdown();
        int                c0;
        logic [TIME_W-1:0] exp_rem;
        logic [3:0]        exp_flags;
        preset_in = 12'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) push_tick(c0 + k * TICK_DIV, TIME_W'(3 - k));
        push_tick(c0 + 4 * TICK_DIV, '0);
        push_tick(c0 + 5 * TICK_DIV, '0);
        for (int t = 0; t <= 24; t++) begin
            if (t > 0) step(1);
            exp_rem   = (t < 12) ? TIME_W'(3 - t / 4) : '0;
            exp_flags = {t < 12, 1'b0, (t >= 12) && (t < 20), t == 12};
            tests++;
            if (remaining !== exp_rem || {running, paused, alarm, done} !== exp_flags) begin
                fails++;
                $display("FAIL countdown t=%0d: rem=%0d flags(r,p,a,d)=%b, expected rem=%0d flags=%b",
                         t, remaining, {running, paused, alarm, done}, exp_rem, exp_flags);
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL countdown_ticks: %0d expected ticks missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_pause_resume();
        int r0;
        preset_in = 12'd5;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        tests++;
        if (paused !== 1'b1 || running !== 1'b0 || remaining !== 12'd5) begin
            fails++;
            $display("FAIL pause_enter: paused=%b running=%b rem=%0d, expected 1 0 5",
                     paused, running, remaining);
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests++;
            if (paused !== 1'b1 || remaining !== 12'd5) begin
                fails++;
                $display("FAIL pause_hold i=%0d: paused=%b rem=%0d, expected 1 5", i, paused,
                         remaining);
            end
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        r0 = cyc;
        push_tick(r0 + 2, 12'd4);
        tests++;
        if (running !== 1'b1 || paused !== 1'b0 || remaining !== 12'd5) begin
            fails++;
            $display("FAIL resume: running=%b paused=%b rem=%0d, expected 1 0 5", running, paused,
                     remaining);
        end
        step(1);
        tests++;
        if (remaining !== 12'd5) begin
            fails++;
            $display("FAIL resume_plus1: rem=%0d, expected 5", remaining);
        end
        step(1);
        tests++;
        if (remaining !== 12'd4 || sec_tick !== 1'b1) begin
            fails++;
            $display("FAIL resume_plus2: rem=%0d sec_tick=%b, expected 4 1", remaining, sec_tick);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        tests++;
        if ({remaining, running, paused, alarm} !== '0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL pause_clear: rem=%0d r/p/a=%b pending=%0d, expected all 0", remaining,
                     {running, paused, alarm}, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_pause_on_wrap();
        int r0;
        preset_in = 12'd2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        tests++;
        if (sec_tick !== 1'b0 || remaining !== 12'd2 || paused !== 1'b1) begin
            fails++;
            $display("FAIL wrap_pause: sec_tick=%b rem=%0d paused=%b, expected 0 2 1", sec_tick,
                     remaining, paused);
        end
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        r0 = cyc;
        push_tick(r0 + 1, 12'd1);
        tests++;
        if (running !== 1'b1 || remaining !== 12'd2 || sec_tick !== 1'b0) begin
            fails++;
            $display("FAIL wrap_resume: running=%b rem=%0d sec_tick=%b, expected 1 2 0", running,
                     remaining, sec_tick);
        end
        step(1);
        tests++;
        if (remaining !== 12'd1 || sec_tick !== 1'b1) begin
            fails++;
            $display("FAIL wrap_tick: rem=%0d sec_tick=%b, expected 1 1", remaining, sec_tick);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        tests++;
        if (exp_q.size() != 0 || remaining !== '0) begin
            fails++;
            $display("FAIL wrap_end: pending=%0d rem=%0d, expected 0 0", exp_q.size(), remaining);
        end
        exp_q.delete();
    endtask

    task automatic test_zero_and_priority();
        preset_in = 12'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL zero_preset: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
        preset_in = 12'd7;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        clear = 1'b1;
        pause = 1'b1;
        start = 1'b1;
        step(1);
        {clear, pause, start} = 3'b000;
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL cmd_priority: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
        step(6);
        tests++;
        if ({remaining, running, paused, alarm} !== '0) begin
            fails++;
            $display("FAIL priority_idle: rem=%0d r/p/a=%b, expected all 0", remaining,
                     {running, paused, alarm});
        end
    endtask

    task automatic test_alarm_ack();
        int c0;
        preset_in = 12'd1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0 = cyc;
        push_tick(c0 + 4, '0);
        step(4);
        tests++;
        if (alarm !== 1'b1 || done !== 1'b1 || remaining !== '0 || running !== 1'b0) begin
            fails++;
            $display("FAIL alarm_enter: alarm=%b done=%b rem=%0d running=%b, expected 1 1 0 0",
                     alarm, done, remaining, running);
        end
        step(1);
        tests++;
        if (alarm !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL alarm_done_width: alarm=%b done=%b, expected 1 0", alarm, done);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL alarm_ack_start: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
        step(6);
        tests++;
        if (running !== 1'b0 || remaining !== '0) begin
            fails++;
            $display("FAIL ack_no_restart: running=%b rem=%0d, expected 0 0", running, remaining);
        end
        preset_in = 12'd2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0 = cyc;
        push_tick(c0 + 4, 12'd1);
        step(4);
        tests++;
        if (running !== 1'b1 || remaining !== 12'd1) begin
            fails++;
            $display("FAIL restart: running=%b rem=%0d, expected 1 1", running, remaining);
        end
        // Let it reach ALARM, then acknowledge with pause instead.
        push_tick(c0 + 8, '0);
        step(4);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        tests++;
        if (alarm !== 1'b0 || running !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL alarm_ack_pause: alarm=%b running=%b pending=%0d, expected 0 0 0",
                     alarm, running, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        int c0;
        preset_in = 12'd4095;
        start = 1'b1;
        step(1);
        start = 1'b0;
        c0 = cyc;
        push_tick(c0 + 4, 12'd4094);
        step(6);
        tests++;
        if (remaining !== 12'd4094 || running !== 1'b1) begin
            fails++;
            $display("FAIL big_preset: rem=%0d running=%b, expected 4094 1", remaining, running);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
            fails++;
            $display("FAIL async_reset: rem=%0d flags=%b, expected all 0", remaining,
                     {sec_tick, running, paused, alarm, done});
        end
        exp_q.delete();
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            tests++;
            if ({remaining, sec_tick, running, paused, alarm, done} !== '0) begin
                fails++;
                $display("FAIL post_reset i=%0d: rem=%0d flags=%b, expected all 0", i, remaining,
                         {sec_tick, running, paused, alarm, done});
            end
        end
    endtask

    initial begin
        fork
            begin : sb_monitor
                tick_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && sec_tick) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL sec_tick_unexpected: tick at cycle %0d rem=%0d, expected none",
                                     cyc, remaining);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.rem !== remaining) begin
                                fails++;
                                $display("FAIL sec_tick_sb: cycle %0d rem=%0d, expected cycle %0d rem=%0d",
                                         cyc, remaining, e.cyc, e.rem);
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_countdown();
        test_pause_resume();
        test_pause_on_wrap();
        test_zero_and_priority();
        test_alarm_ack();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/egg_timer_sequencer.md
# egg_timer_sequencer

Control block for the egg timer. It owns the remaining-time register and a seconds prescaler, and sequences load, run, pause, resume, clear and the alarm phase from single-cycle user commands. It sits between the debounced button logic and the display/buzzer drivers, and exports the remaining seconds and status flags.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick; must be ≥ 2.
- `ALARM_SECS`, default 10: length of the alarm phase in ticks; must be ≥ 1.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `preset_in` in, 12: countdown start value in seconds; sampled only when a start is accepted from IDLE.
- `start` in, 1: one-cycle pulse; start from IDLE, resume from PAUSED, acknowledge in ALARM.
- `pause` in, 1: one-cycle pulse; pause in RUN, acknowledge in ALARM.
- `clear` in, 1: one-cycle pulse; abort to IDLE from any state.
- `remaining` out, 12: seconds left.
- `sec_tick` out, 1: one-cycle pulse for each accepted second while in RUN or ALARM.
- `running` out, 1: high in RUN.
- `paused` out, 1: high in PAUSED.
- `alarm` out, 1: high in ALARM.
- `done` out, 1: one-cycle pulse on the first cycle of ALARM.

## Operation
- States are IDLE, RUN, PAUSED and ALARM. Reset forces IDLE, and all outputs are 0 during and after reset.
- Command priority in the same cycle: `clear` > `pause` > `start`.
- IDLE:
  - `start` with `preset_in` ≠ 0: load `remaining` = `preset_in`, clear the prescaler, go to RUN.
  - `start` with `preset_in` = 0: ignored, stay in IDLE.
  - `pause` and `clear`: no effect.
- RUN:
  - The prescaler counts 0 … `TICK_DIV`-1. On wrap it returns to 0, `sec_tick` pulses and `remaining` decrements.
  - A decrement from 1 to 0 enters ALARM in the same edge.
  - `pause`: go to PAUSED. The prescaler holds its value and any wrap due that cycle is suppressed, so there is no tick and no decrement.
  - `clear`: go to IDLE with `remaining` = 0 and the prescaler = 0.
- PAUSED:
  - Prescaler and `remaining` are frozen.
  - `start`: return to RUN and continue from the held prescaler value. Partial seconds are preserved.
  - `clear`: go to IDLE as in RUN.
  - `pause`: ignored.
- ALARM:
  - `remaining` stays at 0.
  - The prescaler restarts from 0, and an alarm counter counts `sec_tick` pulses.
  - After `ALARM_SECS` ticks, go to IDLE.
  - Any of `start`, `pause` or `clear` acknowledges the alarm and goes to IDLE immediately. A `start` used this way does not also start a new countdown.
- `remaining` never wraps. A decrement is only issued while the value is ≥ 1.
- Reset mid-operation aborts immediately. No pending tick or `done` is emitted after reset is released.

## Timing
- Commands are registered: a command sampled at edge *n* takes effect in state and outputs after edge *n*.
- First decrement: `TICK_DIV` cycles after entering RUN from IDLE.
- Total RUN time: P × `TICK_DIV` cycles for a preset of P with no pauses.
- `done` and `alarm` rise on the same edge on which `remaining` becomes 0.
- `done` stays high for exactly 1 cycle.
- `alarm` stays high for `ALARM_SECS` × `TICK_DIV` cycles unless acknowledged.
- `sec_tick` is high in the same cycle the new `remaining` value is visible.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN, PAUSED, ALARM);
  - `TIME_W` = 12;
  - a function returning the prescaler width as $clog2(`TICK_DIV`).
- One sub-module, `tick_prescaler`, has `clk`, `rst`, `en`, `clr`, output `tick`, and parameter `TICK_DIV`. Its count holds while `en` is low.
- The FSM, the remaining-time register and the alarm counter stay in the top module.

## Test plan
Use `TICK_DIV`=4 and `ALARM_SECS`=2 unless noted.
- Preset 3, `start` → `running`=1 next cycle; `remaining` reads 3→2→1→0 at 4-cycle spacing; `done` pulses for one cycle at 0; `alarm` high for 8 cycles, then IDLE with all flags 0.
- Preset 5, `pause` 2 cycles after entering RUN, hold 10 cycles, then `start` → `remaining` goes 5→4 exactly 2 cycles after resume; no decrement while paused.
- `pause` on the exact wrap cycle with preset 2 → no `sec_tick`, `remaining` stays 2; the tick fires 1 cycle after resume.
- `preset_in`=0 with `start` → stays in IDLE, all outputs 0. Same-cycle `clear`+`pause`+`start` in RUN → IDLE with `remaining`=0.
- In ALARM, pulse `start` → IDLE next cycle and `alarm`=0; the countdown does not restart until a second `start`.
- Assert `rst` mid-RUN with preset 4095 → all outputs 0 immediately. After release, no tick or `done` occurs until a new `start`.
